// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : video_pkg
//  Purpose  : Shared types, palette FSM states and grey-ramp helpers for the
//             palette output stage.
//  Revision : 1.0
// ============================================================================
package video_pkg;

    localparam int C_COLOR_W = 4;
    localparam int C_IDX_W   = 4;

    typedef logic [3*C_COLOR_W-1:0] rgb_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRTY  = 2'd1,
        S_COMMIT = 2'd2
    } pal_state_t;

    // Scales a palette index onto one colour channel of arbitrary width.
    function automatic int ramp_channel(input int idx, input int color_w, input int idx_w);
        if (color_w >= idx_w) begin
            return idx << (color_w - idx_w);
        end
        return idx >> (idx_w - color_w);
    endfunction

    function automatic rgb_t default_ramp(input logic [C_IDX_W-1:0] idx);
        logic [C_COLOR_W-1:0] ch;
        ch = C_COLOR_W'(ramp_channel(int'(idx), C_COLOR_W, C_IDX_W));
        return {ch, ch, ch};
    endfunction

endpackage
`default_nettype wire

// File: rtl/palette_bank.sv
`default_nettype none
// ============================================================================
//  Module   : palette_bank
//  Purpose  : 2**IDX_W-entry RGB register file, reset to a grey ramp, with one
//             write port, one combinational read port and a parallel load.
//  Revision : 1.0
// ============================================================================
module palette_bank
    import video_pkg::*;
#(
    parameter int COLOR_W = 4,
    parameter int IDX_W   = 4
) (
    input  logic                                clk_25,
    input  logic                                rst,
    input  logic                                wr_en,
    input  logic [IDX_W-1:0]                    wr_idx,
    input  logic [3*COLOR_W-1:0]                wr_rgb,
    input  logic                                load,
    input  logic [(2**IDX_W)*3*COLOR_W-1:0]     load_data,
    input  logic [IDX_W-1:0]                    rd_idx,
    output logic [3*COLOR_W-1:0]                rd_rgb,
    output logic [(2**IDX_W)*3*COLOR_W-1:0]     all_data
);

    localparam int C_DEPTH = 2**IDX_W;
    localparam int C_RGB_W = 3*COLOR_W;

    logic [C_DEPTH*C_RGB_W-1:0] w_flat;

    for (genvar i = 0; i < C_DEPTH; i++) begin : g_entry
        localparam logic [COLOR_W-1:0] c_ramp_ch = COLOR_W'(ramp_channel(i, COLOR_W, IDX_W));

        logic [C_RGB_W-1:0] r_entry;

        // A parallel load takes priority so a commit is never split by a write.
        always_ff @(posedge clk_25 or posedge rst) begin
            if (rst) begin
                r_entry <= {c_ramp_ch, c_ramp_ch, c_ramp_ch};
            end else if (load) begin
                r_entry <= load_data[i*C_RGB_W +: C_RGB_W];
            end else if (wr_en && (wr_idx == IDX_W'(i))) begin
                r_entry <= wr_rgb;
            end
        end

        assign w_flat[i*C_RGB_W +: C_RGB_W] = r_entry;
    end

    assign rd_rgb   = w_flat[rd_idx*C_RGB_W +: C_RGB_W];
    assign all_data = w_flat;

endmodule
`default_nettype wire

// File: rtl/palette_output.sv
`default_nettype none
// ============================================================================
//  Module   : palette_output
//  Purpose  : Final video stage: index -> RGB via a double-buffered palette,
//             2-clock pipeline with matched sync delay, black while blanked.
//  Revision : 1.0
// ============================================================================
module palette_output
    import video_pkg::*;
#(
    parameter int   COLOR_W   = 4,
    parameter int   IDX_W     = 4,
    parameter logic SYNC_IDLE = 1'b1
) (
    input  logic                    clk_25,
    input  logic                    rst,
    input  logic [IDX_W-1:0]        pixel_in,
    input  logic                    disp_active,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    frame_end,
    input  logic                    pal_wr_valid,
    output logic                    pal_wr_ready,
    input  logic [IDX_W-1:0]        pal_wr_idx,
    input  logic [3*COLOR_W-1:0]    pal_wr_rgb,
    output logic                    pal_pending,
    output logic [3*COLOR_W-1:0]    rgb_out,
    output logic                    hsync_out,
    output logic                    vsync_out
);

    localparam int C_RGB_W  = 3*COLOR_W;
    localparam int C_FLAT_W = (2**IDX_W)*C_RGB_W;

    pal_state_t             r_state;
    pal_state_t             w_next_state;
    logic                   r_ready;
    logic                   w_wr_accept;
    logic                   w_commit;

    logic [C_FLAT_W-1:0]    w_shadow_flat;
    logic [C_FLAT_W-1:0]    w_live_all_unused;
    logic [C_RGB_W-1:0]     w_shadow_rd_unused;
    logic [C_RGB_W-1:0]     w_live_rd;

    logic [IDX_W-1:0]       r_s1_idx;
    logic                   r_s1_de;
    logic                   r_s1_hs;
    logic                   r_s1_vs;
    logic [C_RGB_W-1:0]     r_rgb;
    logic                   r_hs;
    logic                   r_vs;

    assign w_wr_accept = pal_wr_valid & r_ready;

    // A write landing on frame_end while idle is still committed that frame.
    always_comb begin
        w_next_state = r_state;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr_accept) begin
                    w_next_state = frame_end ? S_COMMIT : S_DIRTY;
                end
            end
            S_DIRTY: begin
                if (frame_end) begin
                    w_next_state = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_commit     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ready <= (w_next_state != S_COMMIT);
        end
    end

    assign pal_wr_ready = r_ready;
    assign pal_pending  = (r_state != S_IDLE);

    palette_bank #(
        .COLOR_W    (COLOR_W),
        .IDX_W      (IDX_W)
    ) u_shadow (
        .clk_25     (clk_25),
        .rst        (rst),
        .wr_en      (w_wr_accept),
        .wr_idx     (pal_wr_idx),
        .wr_rgb     (pal_wr_rgb),
        .load       (1'b0),
        .load_data  ({C_FLAT_W{1'b0}}),
        .rd_idx     ({IDX_W{1'b0}}),
        .rd_rgb     (w_shadow_rd_unused),
        .all_data   (w_shadow_flat)
    );

    palette_bank #(
        .COLOR_W    (COLOR_W),
        .IDX_W      (IDX_W)
    ) u_live (
        .clk_25     (clk_25),
        .rst        (rst),
        .wr_en      (1'b0),
        .wr_idx     ({IDX_W{1'b0}}),
        .wr_rgb     ({C_RGB_W{1'b0}}),
        .load       (w_commit),
        .load_data  (w_shadow_flat),
        .rd_idx     (r_s1_idx),
        .rd_rgb     (w_live_rd),
        .all_data   (w_live_all_unused)
    );

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            r_s1_idx <= '0;
            r_s1_de  <= 1'b0;
            r_s1_hs  <= SYNC_IDLE;
            r_s1_vs  <= SYNC_IDLE;
            r_rgb    <= '0;
            r_hs     <= SYNC_IDLE;
            r_vs     <= SYNC_IDLE;
        end else begin
            r_s1_idx <= pixel_in;
            r_s1_de  <= disp_active;
            r_s1_hs  <= hsync_in;
            r_s1_vs  <= vsync_in;
            r_rgb    <= r_s1_de ? w_live_rd : '0;
            r_hs     <= r_s1_hs;
            r_vs     <= r_s1_vs;
        end
    end

    assign rgb_out   = r_rgb;
    assign hsync_out = r_hs;
    assign vsync_out = r_vs;

endmodule
`default_nettype wire
